ahb_sram_if_pbank: RTL and testbench
====================================

// Module: ahb_sram_if_pbank
// PURPOSE
//   Next-generation AHB-Lite slave front end for the SRAM controller. Sits between the AHB bus and
//   NUM_BANKS banks of byte-wide SRAM macros, each bank DATA_W/8 macros wide.
//   - Parametrised data width and bank count.
//   - Two-cycle ERROR response for illegal size or misaligned transfers.
//   - Single SRAM port per bank; write data phase and next read address phase collide on it.
//     This is resolved by a one-cycle read stall, so back-to-back write->read stays coherent.
// PARAMETERS
//   DATA_W     32  AHB/SRAM data width; 32 or 64. NB = DATA_W/8 byte lanes, OFF_W = log2(NB).
//   BANK_AW    13  SRAM word-address width per bank.
//   NUM_BANKS  2   Number of banks; power of 2, >= 2. BSEL_W = log2(NUM_BANKS).
// PORTS
//   hclk        in   1                 clock
//   hresetn     in   1                 reset, asynchronous, active-low
//   hsel        in   1                 slave select
//   hready      in   1                 bus ready; address phase is sampled only when high
//   hwrite      in   1                 1 = write, 0 = read
//   htrans      in   2                 IDLE/BUSY/NONSEQ/SEQ
//   hsize       in   3                 transfer size, log2(bytes)
//   haddr       in   32                byte address
//   hwdata      in   DATA_W            write data (data phase)
//   hrdata      out  DATA_W            read data
//   hready_out  out  1                 slave ready
//   hresp       out  2                 00 = OKAY, 01 = ERROR
//   sram_csn    out  NUM_BANKS*NB      per-bank, per-byte chip select, active-low; bank b at [b*NB +: NB]
//   sram_we_n   out  1                 0 = write, 1 = read
//   sram_addr   out  BANK_AW           word address, shared by all banks
//   sram_wdata  out  DATA_W            equals hwdata
//   sram_rdata  in   NUM_BANKS*DATA_W  synchronous SRAM read data, 1-cycle latency; bank b at [b*DATA_W +: DATA_W]
// BEHAVIOUR
//   Decode: word = haddr[OFF_W+BANK_AW-1:OFF_W]; bank = next BSEL_W bits; higher bits ignored (aliasing).
//   Accept: hsel & hready & htrans[1]. IDLE/BUSY or no select -> OKAY, zero wait, no SRAM access.
//   Lane mask: size = NB -> all lanes. Smaller sizes -> the 2^hsize lanes starting at the address offset.
//   Illegal if hsize > OFF_W, or if offset is not a multiple of 2^hsize.
//   FSM states: IDLE, WR (write data phase), RD (read data phase), RDSTL (read stalled), ERR1, ERR2.
//   - Accepted illegal transfer -> ERR1: hresp=01, hready_out=0.
//       Next cycle ERR2: hresp=01, hready_out=1. No csn asserted in either cycle.
//   - Accepted write -> WR.
//       Registered address/lane mask drive the SRAM with hwdata: we_n=0, selected bank csn=~mask.
//       Zero wait states.
//   - Accepted read while not in WR -> SRAM read is issued the same cycle from haddr decode
//       (we_n=1, bank csn all lanes 0). Next cycle RD: hrdata = registered-bank slice of sram_rdata,
//       hready_out=1.
//   - Accepted read while in WR (port collision) -> write completes this cycle (hready_out=1).
//       Read address/bank are registered. Next cycle RDSTL: read issued from registers, hready_out=0.
//       Following cycle RD completes. Read-after-write to the same address returns the new data.
//   - hrdata is a full DATA_W word; the master picks lanes. hrdata holds its last value outside RD.
//       hrdata resets to 0.
//   - In ERR1 and RDSTL, hready_out=0, so no new address phase is accepted.
//       In ERR2 and RD a new transfer may be accepted and is processed normally.
//   - Reset values: hready_out=1, hresp=00, sram_csn all 1, sram_we_n=1, sram_addr=0, hrdata=0, FSM=IDLE.
//       Reset asserted mid-transfer forces these immediately; the pending access is dropped.
//   - sram_csn is all 1 whenever no write or read is issued that cycle.
// STRUCTURE
//   Package ahb_sram_pkg:
//     - htrans encodings (IDLE/BUSY/NONSEQ/SEQ); hresp encodings (OKAY/ERROR)
//     - FSM state enum
//     - function lane_mask(hsize, offset, NB)
//   Sub-module ahb_sram_lane_dec (combinational): hsize + offset -> NB-bit lane mask + illegal flag.
//   Top level holds: address/control registers, FSM, SRAM port mux, read-bank select register.
// TESTING  (DATA_W=32, BANK_AW=13, NUM_BANKS=2)
//   1 Word write 0x0000_0010 = 0xDEADBEEF, then back-to-back word read 0x10:
//       write cycle -> csn=8'hF0, addr=4, we_n=0; read -> one RDSTL wait, then hrdata=0xDEADBEEF.
//   2 Byte write 0x0000_8003 hsize=0, hwdata=0xAB00_0000 -> csn=8'h7F (bank1 lane3), addr=0.
//       Later word read 0x8000 -> hrdata[31:24]=0xAB, zero wait.
//   3 Halfword access 0x0000_0001 -> hresp=01 with hready_out 0 then 1; csn stays 8'hFF.
//       hsize=3 at 0x0000_0000 -> same ERROR sequence.
//   4 hsel=1, hready=0, NONSEQ write 0x20 -> not captured; csn stays 8'hFF, FSM stays IDLE.
//       Same transfer with hready=1 -> accepted and written.
//   5 hresetn pulled low during RDSTL -> same cycle: hready_out=1, csn=8'hFF, we_n=1.
//       After release: IDLE, and a word read 0x10 returns stored data with zero wait.
//   6 Seq reads 0x0,0x4,0x8,0xC with no writes -> 4 consecutive hready_out=1 data phases,
//       addr 0..3 issued in the address-phase cycles.

Source files
------------

// File: rtl/ahb_sram_if_pbank_pkg.sv
// Shared encodings, FSM states and lane-mask helper
// for the banked AHB SRAM front end.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDSTL,
    S_ERR1,
    S_ERR2
  } state_e;

  function automatic logic [7:0] lane_mask(
    input logic [2:0] hsize,
    input logic [2:0] offset,
    input int         nb
  );
    logic [7:0] m;
    case (hsize)
      3'd0:    m = 8'h01;
      3'd1:    m = 8'h03;
      3'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    m = m << offset;
    for (int i = 0; i < 8; i++)
      if (i >= nb) m[i] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/ahb_sram_if_pbank_lane_dec.sv
// Byte-lane decoder: size + address offset
// to lane mask, flags oversize/misaligned.
module ahb_sram_lane_dec
  import ahb_sram_pkg::*;
#(
  parameter int NB    = 4,
  parameter int OFF_W = 2
) (
  input  logic [2:0]       i_hsize,
  input  logic [OFF_W-1:0] i_off,
  output logic [NB-1:0]    o_mask,
  output logic             o_illegal
);

  logic [7:0] w_m8;
  logic       w_mis;

  always_comb begin
    w_m8  = lane_mask(i_hsize, 3'(i_off), NB);
    w_mis = 1'b0;
    for (int i = 0; i < OFF_W; i++)
      if ((3'(i) < i_hsize) && i_off[i]) w_mis = 1'b1;
  end

  assign o_mask    = w_m8[NB-1:0];
  assign o_illegal = (i_hsize > 3'(OFF_W)) | w_mis;

endmodule

// File: rtl/ahb_sram_if_pbank.sv
// AHB-Lite slave front end for banked byte-wide SRAM,
// with write->read port-collision stall and 2-cycle ERROR.
module ahb_sram_if_pbank
  import ahb_sram_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BANK_AW   = 13,
  parameter int NUM_BANKS = 2
) (
  input  logic                          hclk,
  input  logic                          hresetn,
  input  logic                          hsel,
  input  logic                          hready,
  input  logic                          hwrite,
  input  logic [1:0]                    htrans,
  input  logic [2:0]                    hsize,
  input  logic [31:0]                   haddr,
  input  logic [DATA_W-1:0]             hwdata,
  output logic [DATA_W-1:0]             hrdata,
  output logic                          hready_out,
  output logic [1:0]                    hresp,
  output logic [NUM_BANKS*DATA_W/8-1:0] sram_csn,
  output logic                          sram_we_n,
  output logic [BANK_AW-1:0]            sram_addr,
  output logic [DATA_W-1:0]             sram_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0]   sram_rdata
);

  localparam int NB     = DATA_W / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int BSEL_W = $clog2(NUM_BANKS);

  state_e              r_state, w_next;
  logic [BANK_AW-1:0]  r_addr;
  logic [BSEL_W-1:0]   r_bank, r_rbank;
  logic [NB-1:0]       r_mask;
  logic [DATA_W-1:0]   r_hrdata;

  logic [BANK_AW-1:0]  w_word;
  logic [BSEL_W-1:0]   w_bank, w_bsel;
  logic [OFF_W-1:0]    w_off;
  logic [NB-1:0]       w_mask, w_lanes;
  logic                w_illegal, w_open;
  logic                w_accept, w_rd_now, w_en;
  logic [DATA_W-1:0]   w_rslice;

  assign w_word = haddr[OFF_W +: BANK_AW];
  assign w_bank = haddr[OFF_W+BANK_AW +: BSEL_W];
  assign w_off  = haddr[OFF_W-1:0];

  ahb_sram_lane_dec #(
    .NB    (NB),
    .OFF_W (OFF_W)
  ) u_lane (
    .i_hsize   (hsize),
    .i_off     (w_off),
    .o_mask    (w_mask),
    .o_illegal (w_illegal)
  );

  // ERR1/RDSTL hold the bus, so no address phase can land there
  assign w_open   = (r_state != S_ERR1) && (r_state != S_RDSTL);
  assign w_accept = hresetn & w_open & hsel & hready & htrans[1];
  assign w_rd_now = w_accept & ~w_illegal & ~hwrite
                  & (r_state != S_WR);

  always_comb begin
    w_next     = S_IDLE;
    hready_out = 1'b1;
    hresp      = HRESP_OKAY;
    sram_csn   = '1;
    sram_we_n  = 1'b1;
    sram_addr  = r_addr;
    w_bsel     = r_bank;
    w_lanes    = '0;
    w_en       = 1'b0;
    case (r_state)
      S_ERR1: begin
        w_next     = S_ERR2;
        hready_out = 1'b0;
        hresp      = HRESP_ERROR;
      end
      S_ERR2:  hresp = HRESP_ERROR;
      S_RDSTL: begin
        w_next     = S_RD;
        hready_out = 1'b0;
        w_en       = 1'b1;
        w_lanes    = '1;
      end
      S_WR: begin
        sram_we_n = 1'b0;
        w_en      = 1'b1;
        w_lanes   = r_mask;
      end
      default: ;
    endcase
    if (w_rd_now) begin
      w_en      = 1'b1;
      w_lanes   = '1;
      w_bsel    = w_bank;
      sram_addr = w_word;
    end
    if (w_accept) begin
      if (w_illegal)           w_next = S_ERR1;
      else if (hwrite)         w_next = S_WR;
      else if (r_state == S_WR) w_next = S_RDSTL;
      else                     w_next = S_RD;
    end
    for (int b = 0; b < NUM_BANKS; b++)
      if (w_en && (BSEL_W'(b) == w_bsel))
        sram_csn[b*NB +: NB] = ~w_lanes;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_bank   <= '0;
      r_rbank  <= '0;
      r_mask   <= '0;
      r_hrdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= w_word;
        r_bank <= w_bank;
        r_mask <= w_mask;
      end
      if (r_state == S_RDSTL) r_rbank <= r_bank;
      else if (w_rd_now)      r_rbank <= w_bank;
      if (r_state == S_RD)    r_hrdata <= w_rslice;
    end
  end

  assign w_rslice   = sram_rdata[r_rbank*DATA_W +: DATA_W];
  assign hrdata     = (r_state == S_RD) ? w_rslice : r_hrdata;
  assign sram_wdata = hwdata;

endmodule

// File: tb/tb_ahb_sram_if_pbank.sv
// Directed bench for ahb_sram_if_pbank with a
// behavioural 2-bank byte-lane SRAM model.
module tb_ahb_sram_if_pbank;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel, hready, hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [7:0]  sram_csn;
  logic        sram_we_n;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [2][4][8192];

  always #5 hclk = ~hclk;

  ahb_sram_if_pbank #(
    .DATA_W    (32),
    .BANK_AW   (13),
    .NUM_BANKS (2)
  ) u_dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .hsel       (hsel),
    .hready     (hready),
    .hwrite     (hwrite),
    .htrans     (htrans),
    .hsize      (hsize),
    .haddr      (haddr),
    .hwdata     (hwdata),
    .hrdata     (hrdata),
    .hready_out (hready_out),
    .hresp      (hresp),
    .sram_csn   (sram_csn),
    .sram_we_n  (sram_we_n),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always @(posedge hclk) begin
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < 4; l++)
        if (!sram_csn[b*4+l]) begin
          if (!sram_we_n)
            mem[b][l][sram_addr] <= sram_wdata[l*8 +: 8];
          else
            sram_rdata[b*32+l*8 +: 8] <= mem[b][l][sram_addr];
        end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic s, input logic r,
                     input logic w, input logic [1:0] t,
                     input logic [2:0] sz, input logic [31:0] a);
    hsel   = s;
    hready = r;
    hwrite = w;
    htrans = t;
    hsize  = sz;
    haddr  = a;
  endtask

  task automatic idle_in;
    drv(1'b0, 1'b1, 1'b0, 2'b00, 3'd0, 32'h0);
  endtask

  task automatic nxt;
    @(posedge hclk);
    #1;
  endtask

  task automatic smp;
    @(negedge hclk);
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < 4; l++)
        for (int a = 0; a < 8192; a++)
          mem[b][l][a] = 8'h00;
    sram_rdata = '0;
    hresetn    = 1'b0;
    hwdata     = '0;
    idle_in();
    smp();
    chk("rst_rdy",  64'(hready_out), 64'h1);
    chk("rst_resp", 64'(hresp),      64'h0);
    chk("rst_csn",  64'(sram_csn),   64'hFF);
    chk("rst_we",   64'(sram_we_n),  64'h1);
    chk("rst_addr", 64'(sram_addr),  64'h0);
    chk("rst_rd",   64'(hrdata),     64'h0);
    nxt();
    hresetn = 1'b1;

    // 1: word write then back-to-back read, one stall
    drv(1, 1, 1, 2'b10, 3'd2, 32'h10);
    smp();
    chk("t1_aph_csn", 64'(sram_csn), 64'hFF);
    nxt();
    hwdata = 32'hDEADBEEF;
    drv(1, 1, 0, 2'b10, 3'd2, 32'h10);
    smp();
    chk("t1_wr_csn",  64'(sram_csn),   64'hF0);
    chk("t1_wr_addr", 64'(sram_addr),  64'h4);
    chk("t1_wr_we",   64'(sram_we_n),  64'h0);
    chk("t1_wr_rdy",  64'(hready_out), 64'h1);
    nxt();
    idle_in();
    smp();
    chk("t1_stl_rdy", 64'(hready_out), 64'h0);
    chk("t1_stl_csn", 64'(sram_csn),   64'hF0);
    chk("t1_stl_we",  64'(sram_we_n),  64'h1);
    nxt();
    smp();
    chk("t1_rd_rdy",  64'(hready_out), 64'h1);
    chk("t1_rd_data", 64'(hrdata),     64'hDEADBEEF);

    // 2: byte write bank1 lane3, later word read
    nxt();
    drv(1, 1, 1, 2'b10, 3'd0, 32'h8003);
    nxt();
    hwdata = 32'hAB00_0000;
    idle_in();
    smp();
    chk("t2_wr_csn",  64'(sram_csn),  64'h7F);
    chk("t2_wr_addr", 64'(sram_addr), 64'h0);
    chk("t2_wr_we",   64'(sram_we_n), 64'h0);
    nxt();
    drv(1, 1, 0, 2'b10, 3'd2, 32'h8000);
    smp();
    chk("t2_rd_csn", 64'(sram_csn),   64'h0F);
    chk("t2_rd_rdy", 64'(hready_out), 64'h1);
    nxt();
    idle_in();
    smp();
    chk("t2_dp_rdy",  64'(hready_out),    64'h1);
    chk("t2_dp_byte", 64'(hrdata[31:24]), 64'hAB);

    // 3: misaligned halfword, then oversize
    nxt();
    drv(1, 1, 0, 2'b10, 3'd1, 32'h1);
    smp();
    chk("t3a_aph_csn", 64'(sram_csn), 64'hFF);
    nxt();
    idle_in();
    smp();
    chk("t3a_e1_resp", 64'(hresp),      64'h1);
    chk("t3a_e1_rdy",  64'(hready_out), 64'h0);
    chk("t3a_e1_csn",  64'(sram_csn),   64'hFF);
    nxt();
    smp();
    chk("t3a_e2_resp", 64'(hresp),      64'h1);
    chk("t3a_e2_rdy",  64'(hready_out), 64'h1);
    chk("t3a_e2_csn",  64'(sram_csn),   64'hFF);
    nxt();
    drv(1, 1, 0, 2'b10, 3'd3, 32'h0);
    smp();
    chk("t3b_aph_resp", 64'(hresp),    64'h0);
    chk("t3b_aph_csn",  64'(sram_csn), 64'hFF);
    nxt();
    idle_in();
    smp();
    chk("t3b_e1_resp", 64'(hresp),      64'h1);
    chk("t3b_e1_rdy",  64'(hready_out), 64'h0);
    nxt();
    smp();
    chk("t3b_e2_resp", 64'(hresp),      64'h1);
    chk("t3b_e2_rdy",  64'(hready_out), 64'h1);

    // 4: hready low blocks capture
    nxt();
    drv(1, 0, 1, 2'b10, 3'd2, 32'h20);
    smp();
    chk("t4_blk_csn", 64'(sram_csn), 64'hFF);
    nxt();
    idle_in();
    hwdata = 32'h1234_5678;
    smp();
    chk("t4_blk_csn2", 64'(sram_csn),  64'hFF);
    chk("t4_blk_we",   64'(sram_we_n), 64'h1);
    chk("t4_blk_resp", 64'(hresp),     64'h0);
    nxt();
    drv(1, 1, 1, 2'b10, 3'd2, 32'h20);
    smp();
    chk("t4_aph_csn", 64'(sram_csn), 64'hFF);
    nxt();
    idle_in();
    smp();
    chk("t4_wr_csn",  64'(sram_csn),  64'hF0);
    chk("t4_wr_addr", 64'(sram_addr), 64'h8);
    chk("t4_wr_we",   64'(sram_we_n), 64'h0);

    // 5: reset during a read stall
    nxt();
    drv(1, 1, 1, 2'b10, 3'd2, 32'h14);
    nxt();
    hwdata = 32'h55AA_55AA;
    drv(1, 1, 0, 2'b10, 3'd2, 32'h10);
    smp();
    chk("t5_wr_addr", 64'(sram_addr), 64'h5);
    nxt();
    idle_in();
    smp();
    chk("t5_stl_rdy", 64'(hready_out), 64'h0);
    #1;
    hresetn = 1'b0;
    #1;
    chk("t5_rst_rdy",  64'(hready_out), 64'h1);
    chk("t5_rst_csn",  64'(sram_csn),   64'hFF);
    chk("t5_rst_we",   64'(sram_we_n),  64'h1);
    chk("t5_rst_resp", 64'(hresp),      64'h0);
    chk("t5_rst_rd",   64'(hrdata),     64'h0);
    nxt();
    hresetn = 1'b1;
    drv(1, 1, 0, 2'b10, 3'd2, 32'h10);
    smp();
    chk("t5_rd_csn",  64'(sram_csn),   64'hF0);
    chk("t5_rd_addr", 64'(sram_addr),  64'h4);
    chk("t5_rd_rdy",  64'(hready_out), 64'h1);
    nxt();
    idle_in();
    smp();
    chk("t5_dp_rdy",  64'(hready_out), 64'h1);
    chk("t5_dp_data", 64'(hrdata),     64'hDEADBEEF);

    // preload words 1 and 3 with back-to-back writes
    nxt();
    drv(1, 1, 1, 2'b10, 3'd2, 32'h4);
    nxt();
    hwdata = 32'h0BAD_F00D;
    drv(1, 1, 1, 2'b10, 3'd2, 32'hC);
    smp();
    chk("t6p_w1_addr", 64'(sram_addr), 64'h1);
    nxt();
    hwdata = 32'h0123_4567;
    idle_in();
    smp();
    chk("t6p_w3_addr", 64'(sram_addr), 64'h3);
    chk("t6p_w3_we",   64'(sram_we_n), 64'h0);

    // 6: pipelined reads, no stalls
    nxt();
    drv(1, 1, 0, 2'b10, 3'd2, 32'h0);
    smp();
    chk("t6_a0_addr", 64'(sram_addr), 64'h0);
    chk("t6_a0_csn",  64'(sram_csn),  64'hF0);
    nxt();
    drv(1, 1, 0, 2'b11, 3'd2, 32'h4);
    smp();
    chk("t6_a1_addr", 64'(sram_addr),  64'h1);
    chk("t6_d0_rdy",  64'(hready_out), 64'h1);
    chk("t6_d0_data", 64'(hrdata),     64'h0);
    nxt();
    drv(1, 1, 0, 2'b11, 3'd2, 32'h8);
    smp();
    chk("t6_a2_addr", 64'(sram_addr),  64'h2);
    chk("t6_d1_rdy",  64'(hready_out), 64'h1);
    chk("t6_d1_data", 64'(hrdata),     64'h0BADF00D);
    nxt();
    drv(1, 1, 0, 2'b11, 3'd2, 32'hC);
    smp();
    chk("t6_a3_addr", 64'(sram_addr),  64'h3);
    chk("t6_d2_rdy",  64'(hready_out), 64'h1);
    chk("t6_d2_data", 64'(hrdata),     64'h0);
    nxt();
    idle_in();
    smp();
    chk("t6_d3_rdy",  64'(hready_out), 64'h1);
    chk("t6_d3_data", 64'(hrdata),     64'h01234567);
    chk("t6_idle_csn", 64'(sram_csn),  64'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
